// File: rtl/scpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : scpu_run_ctrl
//  Purpose  : Run/halt/step controller with one PC breakpoint for the
//             single-cycle RISC-V core. Drives the core clock-enable, gates
//             the data-memory write strobe and counts retired instructions.
//  Revision : 1.0  initial release
// ============================================================================
module scpu_run_ctrl #(
  parameter bit RESET_RUN = 1'b0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_cmd,
  input  logic             halt_cmd,
  input  logic             step_cmd,
  input  logic [7:0]       step_count,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  input  logic             mem_w_in,
  output logic             cpu_en,
  output logic             mem_w_out,
  output logic             halted,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] ST_HALT  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_STEP  = 2'b10;
  localparam logic [1:0] ST_BREAK = 2'b11;
  localparam logic [1:0] ST_RESET = RESET_RUN ? ST_RUN : ST_HALT;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] cur_state;
  logic [1:0] nxt_state;
  logic [7:0] step_left;
  logic [7:0] nxt_step_left;
  logic       skip_bp;
  logic       nxt_skip_bp;
  logic       hit_flag;
  logic       nxt_hit_flag;

  logic       active;
  logic       bp_match;
  logic       exec_en;

  // Executing states; the breakpoint is masked for one retire after resuming
  // so the instruction sitting at bp_addr can be executed once.
  assign active   = (cur_state == ST_RUN) || (cur_state == ST_STEP);
  assign bp_match = bp_en && (pc == bp_addr) && !skip_bp;
  // Combinational so halt and breakpoint suppress the instruction in-cycle.
  assign exec_en  = active && !halt_cmd && !bp_match;

  // State register together with the step counter and breakpoint flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= ST_RESET;
      step_left <= 8'd0;
      skip_bp   <= 1'b0;
      hit_flag  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      step_left <= nxt_step_left;
      skip_bp   <= nxt_skip_bp;
      hit_flag  <= nxt_hit_flag;
    end
  end

  // Next-state logic; halt beats breakpoint, which beats every other command.
  always_comb begin
    nxt_state     = cur_state;
    nxt_step_left = step_left;
    nxt_skip_bp   = skip_bp;
    nxt_hit_flag  = hit_flag;

    // The first retire after resuming re-arms the breakpoint.
    if (exec_en) begin
      nxt_skip_bp = 1'b0;
    end

    case (cur_state)
      ST_HALT, ST_BREAK: begin
        if (!halt_cmd) begin
          if (step_cmd) begin
            nxt_state     = ST_STEP;
            nxt_step_left = (step_count == 8'd0) ? 8'd1 : step_count;
            nxt_hit_flag  = 1'b0;
            nxt_skip_bp   = 1'b1;
          end else if (run_cmd) begin
            nxt_state    = ST_RUN;
            nxt_hit_flag = 1'b0;
            nxt_skip_bp  = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (halt_cmd) begin
          nxt_state = ST_HALT;
        end else if (bp_match) begin
          nxt_state    = ST_BREAK;
          nxt_hit_flag = 1'b1;
        end
      end

      ST_STEP: begin
        if (halt_cmd) begin
          nxt_state = ST_HALT;
        end else if (bp_match) begin
          nxt_state    = ST_BREAK;
          nxt_hit_flag = 1'b1;
        end else if (run_cmd) begin
          // Promote the step into free-running; skip_bp is left as is.
          nxt_state = ST_RUN;
        end else if (exec_en) begin
          if (step_left == 8'd1) begin
            nxt_state = ST_HALT;
          end else begin
            nxt_step_left = step_left - 8'd1;
          end
        end
      end

      default: begin
        nxt_state = ST_HALT;
      end
    endcase
  end

  // Output decode from the current state and the in-cycle enable.
  always_comb begin
    cpu_en    = exec_en;
    mem_w_out = mem_w_in && exec_en;
    halted    = (cur_state == ST_HALT) || (cur_state == ST_BREAK);
    state     = cur_state;
    bp_hit    = hit_flag;
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret <= '0;
    end else if (exec_en) begin
      instret <= instret + CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scpu_run_ctrl
//  Purpose  : Scoreboard bench for scpu_run_ctrl. Two instances share the
//             command inputs: A (halt after reset, 32-bit counter) and
//             B (run after reset, 4-bit counter). Each drives a tiny core
//             PC that loops over 0x00..0x3C.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset, run_cmd, halt_cmd, step_cmd, bp_en, mem_w_in;
  logic [7:0]  step_count;
  logic [31:0] bp_addr;
  logic [31:0] pc_a, pc_b;

  logic        cpu_en_a, mem_w_out_a, halted_a, bp_hit_a;
  logic [1:0]  state_a;
  logic [31:0] instret_a;
  logic        cpu_en_b, mem_w_out_b, halted_b, bp_hit_b;
  logic [1:0]  state_b;
  logic [3:0]  instret_b;

  always #5 clk = ~clk;

  scpu_run_ctrl #(.RESET_RUN(1'b0), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .run_cmd(run_cmd), .halt_cmd(halt_cmd),
    .step_cmd(step_cmd), .step_count(step_count), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc_a), .mem_w_in(mem_w_in), .cpu_en(cpu_en_a),
    .mem_w_out(mem_w_out_a), .halted(halted_a), .state(state_a),
    .bp_hit(bp_hit_a), .instret(instret_a));

  scpu_run_ctrl #(.RESET_RUN(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .run_cmd(run_cmd), .halt_cmd(halt_cmd),
    .step_cmd(step_cmd), .step_count(step_count), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc_b), .mem_w_in(mem_w_in), .cpu_en(cpu_en_b),
    .mem_w_out(mem_w_out_b), .halted(halted_b), .state(state_b),
    .bp_hit(bp_hit_b), .instret(instret_b));

  // Minimal core: PC advances by 4 on each enabled cycle, looping at 0x3C.
  always @(posedge clk) begin
    if (reset) pc_a <= 32'd0;
    else if (cpu_en_a) pc_a <= (pc_a == 32'h3C) ? 32'd0 : pc_a + 32'd4;
    if (reset) pc_b <= 32'd0;
    else if (cpu_en_b) pc_b <= (pc_b == 32'h3C) ? 32'd0 : pc_b + 32'd4;
  end

  // ---------------- reference model ----------------
  // st: 0 HALT, 1 RUN, 2 STEP, 3 BREAK
  typedef struct {
    bit              valid;
    int              st;
    int              left;
    bit              skip;
    bit              hit;
    longint unsigned ir;
  } mdl_t;

  typedef struct {
    bit              chk;
    bit              chk_en;
    bit              en;
    bit              mw;
    bit              hlt;
    int              st;
    bit              hit;
    longint unsigned ir;
  } exp_t;

  mdl_t            m [2];
  exp_t            qa [$];
  exp_t            qb [$];
  longint unsigned modv [2];
  int              rst_st [2];
  int              checks = 0;
  int              errors = 0;

  function automatic bit model_en(mdl_t s, logic [31:0] pcv);
    bit act, bpm;
    act = (s.st == 1) || (s.st == 2);
    bpm = bp_en && (pcv == bp_addr) && !s.skip;
    return act && !halt_cmd && !bpm;
  endfunction

  function automatic mdl_t model_next(mdl_t s, int k, logic [31:0] pcv);
    mdl_t n;
    bit   en, bpm;
    n   = s;
    en  = model_en(s, pcv);
    bpm = bp_en && (pcv == bp_addr) && !s.skip;
    if (reset) begin
      n.valid = 1'b1; n.st = rst_st[k]; n.left = 0;
      n.skip = 1'b0; n.hit = 1'b0; n.ir = 0;
      return n;
    end
    if (en) begin
      n.ir   = (s.ir + 1) % modv[k];
      n.skip = 1'b0;
    end
    if (s.st == 0 || s.st == 3) begin
      if (halt_cmd) begin
        // stay halted
      end else if (step_cmd) begin
        n.st = 2; n.left = (step_count == 0) ? 1 : int'(step_count);
        n.hit = 1'b0; n.skip = 1'b1;
      end else if (run_cmd) begin
        n.st = 1; n.hit = 1'b0; n.skip = 1'b1;
      end
    end else if (halt_cmd) begin
      n.st = 0;
    end else if (bpm) begin
      n.st = 3; n.hit = 1'b1;
    end else if (s.st == 2) begin
      if (run_cmd) n.st = 1;
      else if (en && s.left == 1) n.st = 0;
      else if (en) n.left = s.left - 1;
    end
    return n;
  endfunction

  function automatic exp_t model_out(mdl_t s, logic [31:0] pcv);
    exp_t e;
    e.chk    = s.valid;
    e.chk_en = s.valid && !reset;
    e.en     = model_en(s, pcv);
    e.mw     = e.en && mem_w_in;
    e.hlt    = (s.st == 0) || (s.st == 3);
    e.st     = s.st;
    e.hit    = s.hit;
    e.ir     = s.ir;
    return e;
  endfunction

  // One cycle of stimulus: drive, record expectation, advance the model.
  task automatic tick(input bit r, input bit rc, input bit hc, input bit sc,
                      input logic [7:0] cnt);
    logic [31:0] pa, pb;
    reset = r; run_cmd = rc; halt_cmd = hc; step_cmd = sc; step_count = cnt;
    pa = pc_a; pb = pc_b;
    qa.push_back(model_out(m[0], pa));
    qb.push_back(model_out(m[1], pb));
    @(posedge clk);
    m[0] = model_next(m[0], 0, pa);
    m[1] = model_next(m[1], 1, pb);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  // ---------------- monitor ----------------
  task automatic cmp(input string name, input longint unsigned act,
                     input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_inst(input string p, input exp_t e, input logic en,
                            input logic mw, input logic hl, input logic [1:0] st,
                            input logic hit, input longint unsigned ir);
    if (e.chk_en) begin
      cmp({p, "cpu_en"}, 64'(en), 64'(e.en));
      cmp({p, "mem_w_out"}, 64'(mw), 64'(e.mw));
    end
    if (e.chk) begin
      cmp({p, "halted"}, 64'(hl), 64'(e.hlt));
      cmp({p, "state"}, 64'(st), 64'(e.st));
      cmp({p, "bp_hit"}, 64'(hit), 64'(e.hit));
      cmp({p, "instret"}, ir, e.ir);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check_inst("a_", e, cpu_en_a, mem_w_out_a, halted_a, state_a, bp_hit_a,
                 64'(instret_a));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check_inst("b_", e, cpu_en_b, mem_w_out_b, halted_b, state_b, bp_hit_b,
                 64'(instret_b));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    modv[0] = 64'd1 << 32; modv[1] = 64'd16;
    rst_st[0] = 0;         rst_st[1] = 1;
    m[0] = '{valid: 1'b0, st: 0, left: 0, skip: 1'b0, hit: 1'b0, ir: 0};
    m[1] = m[0];
    reset = 1'b1; run_cmd = 1'b0; halt_cmd = 1'b0; step_cmd = 1'b0;
    step_count = 8'd0; bp_en = 1'b0; bp_addr = 32'd0; mem_w_in = 1'b0;
    @(posedge clk); #1;

    // Reset, then a step of 3 and a step of 0 (treated as 1).
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
    idle(6);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    idle(4);

    // Breakpoint at 0x10 from PC 0, resume, and loop back onto it.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    bp_en = 1'b1; bp_addr = 32'h10;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    idle(10);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    idle(24);

    // Store every cycle while running, then halt.
    bp_en = 1'b0; mem_w_in = 1'b1;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    idle(5);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    idle(5);
    mem_w_in = 1'b0;

    // Long step promoted to RUN, then halt coinciding with a breakpoint.
    tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd200);
    idle(5);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    idle(10);
    bp_en = 1'b1; bp_addr = pc_a;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    idle(3);
    bp_en = 1'b0;

    // B runs from reset: 17 retires wrap its 4-bit counter; reset mid-run.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    idle(17);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    idle(3);

    // Randomized commands, breakpoints and stores.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) bp_en = ~bp_en;
      if ($urandom_range(0, 29) == 0) bp_addr = 32'($urandom_range(0, 15)) << 2;
      mem_w_in = 1'($urandom_range(0, 1));
      tick(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12)));
    end

    idle(2);
    @(negedge clk); #1;
    cmp("queue_a_drained", 64'(qa.size()), 64'd0);
    cmp("queue_b_drained", 64'(qb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
